// File: rtl/awb_stat_accum.sv
// awb_stat_accum: per-frame R/G/B sum accumulator publishing gray-world white-balance statistics.
// Optional clip exclusion via AWB_CLIP_EXCL_EN (HI_THR/LO_THR).
module awb_stat_accum #(
  parameter int DATA_W = 8,
  parameter int HI_THR = 250,
  parameter int LO_THR = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_r,
  input  logic [DATA_W-1:0] pix_g,
  input  logic [DATA_W-1:0] pix_b,
  output logic [31:0]       r_sum,
  output logic [31:0]       g_sum,
  output logic [31:0]       b_sum,
  output logic [31:0]       k_sum,
  output logic [23:0]       pix_cnt,
  output logic              stat_valid,
  output logic              stat_hold
);
  typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;
  state_t r_state, w_next;
  logic [31:0] r_acc_r, r_acc_g, r_acc_b;
  logic [23:0] r_acc_cnt;
  logic [31:0] w_base_r, w_base_g, w_base_b, w_nxt_r, w_nxt_g, w_nxt_b;
  logic [23:0] w_base_cnt, w_nxt_cnt;
  logic        w_accept, w_load, w_add;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [DATA_W-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? '1 : s[31:0];
  endfunction

`ifdef AWB_CLIP_EXCL_EN
  localparam logic [DATA_W-1:0] HI = DATA_W'(HI_THR);
  localparam logic [DATA_W-1:0] LO = DATA_W'(LO_THR);
  assign w_accept = pix_valid && pix_r < HI && pix_g < HI && pix_b < HI &&
                    !(pix_r <= LO && pix_g <= LO && pix_b <= LO);
`else
  assign w_accept = pix_valid;
`endif

  // A start in IDLE, or an abort in ACCUM, reloads the accumulators with the coincident pixel.
  assign w_load = frame_start && (r_state == IDLE || (r_state == ACCUM && !frame_end));
  assign w_add  = r_state == ACCUM && !w_load;

  always_comb begin
    w_next     = r_state;
    w_base_r   = w_load ? '0 : r_acc_r;
    w_base_g   = w_load ? '0 : r_acc_g;
    w_base_b   = w_load ? '0 : r_acc_b;
    w_base_cnt = w_load ? '0 : r_acc_cnt;
    w_nxt_r    = (w_accept && (w_load || w_add)) ? sat_add(w_base_r, pix_r) : w_base_r;
    w_nxt_g    = (w_accept && (w_load || w_add)) ? sat_add(w_base_g, pix_g) : w_base_g;
    w_nxt_b    = (w_accept && (w_load || w_add)) ? sat_add(w_base_b, pix_b) : w_base_b;
    w_nxt_cnt  = (w_accept && (w_load || w_add) && !(&w_base_cnt)) ? w_base_cnt + 24'd1 : w_base_cnt;
    w_next     = r_state == IDLE  ? (frame_start ? ACCUM : IDLE) :
                 r_state == ACCUM ? (frame_end ? PUBLISH : ACCUM) : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc_r   <= '0;
      r_acc_g   <= '0;
      r_acc_b   <= '0;
      r_acc_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_acc_r   <= w_nxt_r;
      r_acc_g   <= w_nxt_g;
      r_acc_b   <= w_nxt_b;
      r_acc_cnt <= w_nxt_cnt;
    end
  end

  // Zero channel sums are floored to 1 so the gain dividers never divide by zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum      <= '0;
      g_sum      <= '0;
      b_sum      <= '0;
      k_sum      <= '0;
      pix_cnt    <= '0;
      stat_valid <= 1'b0;
      stat_hold  <= 1'b0;
    end else begin
      stat_valid <= r_state == PUBLISH;
      if (r_state == PUBLISH) begin
        r_sum     <= r_acc_r == '0 ? 32'd1 : r_acc_r;
        g_sum     <= r_acc_g == '0 ? 32'd1 : r_acc_g;
        b_sum     <= r_acc_b == '0 ? 32'd1 : r_acc_b;
        k_sum     <= r_acc_g;
        pix_cnt   <= r_acc_cnt;
        stat_hold <= 1'b1;
      end else if (r_state == IDLE && frame_start) begin
        stat_hold <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_awb_stat_accum.sv
// tb_awb_stat_accum: directed tests for awb_stat_accum (default build and AWB_CLIP_EXCL_EN).
module tb_awb_stat_accum;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0, frame_end = 1'b0, pix_valid = 1'b0;
  logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0;
  logic [31:0] r_sum, g_sum, b_sum, k_sum;
  logic [23:0] pix_cnt;
  logic        stat_valid, stat_hold;
  int          n_vec = 0, n_err = 0, n_pulse = 0;

  awb_stat_accum #(.DATA_W(8), .HI_THR(250), .LO_THR(5)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .r_sum(r_sum), .g_sum(g_sum), .b_sum(b_sum), .k_sum(k_sum),
    .pix_cnt(pix_cnt), .stat_valid(stat_valid), .stat_hold(stat_hold)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (stat_valid) n_pulse++;

  task automatic step(input logic fs, input logic fe, input logic v,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    frame_start = fs; frame_end = fe; pix_valid = v; pix_r = r; pix_g = g; pix_b = b;
    @(posedge clk); #1;
    frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({r_sum, g_sum, b_sum, k_sum} !== 128'd0) begin n_err++; $display("FAIL reset_sums got %h want 0", {r_sum, g_sum, b_sum, k_sum}); end
    n_vec++; if (pix_cnt !== 24'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", pix_cnt); end
    n_vec++; if ({stat_valid, stat_hold} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {stat_valid, stat_hold}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    n_pulse = 0;
    step(1, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 1, 10, 20, 30);
    step(0, 1, 0, 0, 0, 0);
    n_vec++; if (stat_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got %b want 0", stat_valid); end
    step(0, 0, 0, 0, 0, 0);
    n_vec++; if ({r_sum, g_sum, b_sum} !== {32'd40, 32'd80, 32'd120}) begin n_err++; $display("FAIL basic_sums got %0d/%0d/%0d want 40/80/120", r_sum, g_sum, b_sum); end
    n_vec++; if (k_sum !== 32'd80) begin n_err++; $display("FAIL basic_k got %0d want 80", k_sum); end
    n_vec++; if (pix_cnt !== 24'd4) begin n_err++; $display("FAIL basic_cnt got %0d want 4", pix_cnt); end
    n_vec++; if ({stat_valid, stat_hold} !== 2'b11) begin n_err++; $display("FAIL basic_flags got %b want 11", {stat_valid, stat_hold}); end
    step(0, 0, 0, 0, 0, 0);
    n_vec++; if ({stat_valid, stat_hold} !== 2'b01) begin n_err++; $display("FAIL basic_pulse_end got %b want 01", {stat_valid, stat_hold}); end
    n_vec++; if (r_sum !== 32'd40 || n_pulse != 1) begin n_err++; $display("FAIL basic_stable got r=%0d pulses=%0d want r=40 pulses=1", r_sum, n_pulse); end
  endtask

  task automatic test_edge_pixels;
    step(1, 0, 1, 1, 2, 3);
    n_vec++; if (stat_hold !== 1'b0) begin n_err++; $display("FAIL edge_hold_drop got %b want 0", stat_hold); end
    step(0, 1, 1, 1, 2, 3);
    step(0, 0, 0, 0, 0, 0);
    n_vec++; if ({r_sum, g_sum, b_sum, 8'(pix_cnt)} !== {32'd2, 32'd4, 32'd6, 8'd2}) begin n_err++; $display("FAIL edge_sums got %0d/%0d/%0d cnt %0d want 2/4/6 cnt 2", r_sum, g_sum, b_sum, pix_cnt); end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_empty;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    n_vec++; if ({r_sum, g_sum, b_sum} !== {32'd1, 32'd1, 32'd1}) begin n_err++; $display("FAIL empty_floor got %0d/%0d/%0d want 1/1/1", r_sum, g_sum, b_sum); end
    n_vec++; if (k_sum !== 32'd0 || pix_cnt !== 24'd0) begin n_err++; $display("FAIL empty_k_cnt got k=%0d cnt=%0d want 0/0", k_sum, pix_cnt); end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_abort;
    n_pulse = 0;
    step(1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 100, 100, 100);
    step(1, 0, 0, 0, 0, 0);
    n_vec++; if (n_pulse != 0 || r_sum !== 32'd1) begin n_err++; $display("FAIL abort_no_publish got pulses=%0d r=%0d want 0/1", n_pulse, r_sum); end
    step(0, 0, 1, 5, 6, 7);
    step(0, 1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    n_vec++; if ({r_sum, g_sum, b_sum, 8'(pix_cnt)} !== {32'd5, 32'd6, 32'd7, 8'd1}) begin n_err++; $display("FAIL abort_sums got %0d/%0d/%0d cnt %0d want 5/6/7 cnt 1", r_sum, g_sum, b_sum, pix_cnt); end
    n_vec++; if (n_pulse != 1) begin n_err++; $display("FAIL abort_pulses got %0d want 1", n_pulse); end
  endtask

  task automatic test_saturation;
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 255, 0, 0);
    force dut.r_acc_r = 32'hFFFF_FF80;
    step(0, 0, 1, 255, 0, 0);
    release dut.r_acc_r;
    repeat (2) step(0, 0, 1, 255, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    n_vec++; if (r_sum !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_r got %h want ffffffff", r_sum); end
    n_vec++; if (g_sum !== 32'd1 || pix_cnt !== 24'd4) begin n_err++; $display("FAIL sat_other got g=%0d cnt=%0d want 1/4", g_sum, pix_cnt); end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_clip;
    step(1, 0, 1, 255, 100, 100);
    step(0, 0, 1, 2, 3, 4);
    step(0, 1, 1, 50, 60, 70);
    step(0, 0, 0, 0, 0, 0);
`ifdef AWB_CLIP_EXCL_EN
    n_vec++; if ({r_sum, g_sum, b_sum, 8'(pix_cnt)} !== {32'd50, 32'd60, 32'd70, 8'd1}) begin n_err++; $display("FAIL clip_sums got %0d/%0d/%0d cnt %0d want 50/60/70 cnt 1", r_sum, g_sum, b_sum, pix_cnt); end
`else
    n_vec++; if ({r_sum, g_sum, b_sum, 8'(pix_cnt)} !== {32'd307, 32'd163, 32'd174, 8'd3}) begin n_err++; $display("FAIL clip_sums got %0d/%0d/%0d cnt %0d want 307/163/174 cnt 3", r_sum, g_sum, b_sum, pix_cnt); end
`endif
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_idle_ignore_and_reset;
    n_pulse = 0;
    step(0, 1, 1, 9, 9, 9);
    step(0, 0, 1, 9, 9, 9);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    n_vec++; if (n_pulse != 0 || stat_hold !== 1'b1) begin n_err++; $display("FAIL idle_ignore got pulses=%0d hold=%b want 0/1", n_pulse, stat_hold); end
    step(1, 0, 1, 9, 9, 9);
    step(0, 0, 1, 9, 9, 9);
    rst_n = 1'b0;
    #1;
    n_vec++; if ({r_sum, 8'(pix_cnt), stat_hold} !== 41'd0) begin n_err++; $display("FAIL midreset got r=%0d cnt=%0d hold=%b want 0/0/0", r_sum, pix_cnt, stat_hold); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    n_vec++; if (n_pulse != 0 || r_sum !== 32'd0) begin n_err++; $display("FAIL midreset_lost got pulses=%0d r=%0d want 0/0", n_pulse, r_sum); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_edge_pixels;
    test_empty;
    test_abort;
    test_saturation;
    test_clip;
    test_idle_ignore_and_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
